param_odd_even_sorter: RTL

Parametrised odd-even transposition sorter for the softmax path. It is the successor to the fixed-width systolic max finder.
- Generalised to any element count, odd or even, and any data width.
- Selectable signed/unsigned compare and run-time ascending/descending order.
- Valid/ready handshakes on both input and output; outputs the full sorted vector plus max and min.
- Sits between the output buffer and the softmax exponent stage, which consumes max_out for max subtraction.

---
 rtl/param_odd_even_sorter_pkg.sv | 24 ++
 rtl/param_odd_even_sorter_cmp_exchange_cell.sv | 33 +++
 rtl/param_odd_even_sorter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/param_odd_even_sorter_pkg.sv
// param_odd_even_sorter_pkg: shared types and compare helper for the odd-even sorter
//   MAX_W   : widest element the compare helper handles (DATA_W must not exceed it)
//   wide_t  : element container that every DATA_W is widened into before comparing
//   state_t : sorter control states
//   greater : strict a > b, two's-complement when sgn = 1, unsigned otherwise
package sorter_pkg;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    // Callers widen both operands the same way (sign- or zero-extend), so
    // comparing the widened values gives the DATA_W-wide result.
    function automatic logic greater(input wide_t a, input wide_t b, input logic sgn);
        return sgn ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

endpackage

// File: rtl/param_odd_even_sorter_cmp_exchange_cell.sv
// cmp_exchange_cell: combinational compare-swap of one element pair
//   lo, hi         : pair inputs (lo is the lower lane index)
//   descending     : 0 = put the smaller value in lo, 1 = put the larger value in lo
//   en             : 0 = pass both values straight through
//   lo_out, hi_out : pair outputs
module cmp_exchange_cell
    import sorter_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter bit SIGNED_CMP = 1
) (
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    input  logic              descending,
    input  logic              en,
    output logic [DATA_W-1:0] lo_out,
    output logic [DATA_W-1:0] hi_out
);

    wide_t lo_w;
    wide_t hi_w;
    logic  swap;

    // Strict compare: equal values never swap, which keeps the sort stable.
    always_comb begin
        lo_w   = SIGNED_CMP ? wide_t'($signed(lo)) : wide_t'(lo);
        hi_w   = SIGNED_CMP ? wide_t'($signed(hi)) : wide_t'(hi);
        swap   = en & (descending ? greater(hi_w, lo_w, SIGNED_CMP) : greater(lo_w, hi_w, SIGNED_CMP));
        lo_out = swap ? hi : lo;
        hi_out = swap ? lo : hi;
    end

endmodule

// File: rtl/param_odd_even_sorter.sv
// param_odd_even_sorter: odd-even transposition sorter with valid/ready on both sides
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : input handshake; in_data lane i = bits [(i+1)*DATA_W-1 : i*DATA_W]
//   descending             : sort order, sampled only at the input handshake
//   out_valid/out_ready    : output handshake; out_data uses the same lane packing
//   max_out, min_out       : extreme elements of the sorted vector
//   busy                   : high while phases are running
module param_odd_even_sorter
    import sorter_pkg::*;
#(
    parameter int NUM_ELEM   = 8,
    parameter int DATA_W     = 16,
    parameter bit SIGNED_CMP = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_ELEM*DATA_W-1:0] in_data,
    input  logic                       descending,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_ELEM*DATA_W-1:0] out_data,
    output logic [DATA_W-1:0]          max_out,
    output logic [DATA_W-1:0]          min_out,
    output logic                       busy
);

    localparam int CNT_W  = $clog2(NUM_ELEM + 1);
    localparam int N_EVEN = NUM_ELEM / 2;
    localparam int N_ODD  = (NUM_ELEM - 1) / 2;

    state_t            state;
    logic              desc;
    logic [CNT_W-1:0]  phase;
    logic              capture;
    logic [DATA_W-1:0] e       [NUM_ELEM];
    logic [DATA_W-1:0] in_elem [NUM_ELEM];
    logic [DATA_W-1:0] even_n  [NUM_ELEM];
    logic [DATA_W-1:0] odd_n   [NUM_ELEM];

    // In DONE the sorter can take a new vector exactly when the old result leaves.
    assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
    assign capture  = in_valid && in_ready;

    for (genvar i = 0; i < NUM_ELEM; i++) begin : g_lane
        assign in_elem[i]                        = in_data[i*DATA_W +: DATA_W];
        assign out_data[i*DATA_W +: DATA_W]      = e[i];
    end

    // Even network: pairs (0,1), (2,3), ...
    for (genvar i = 0; i < N_EVEN; i++) begin : g_even
        cmp_exchange_cell #(
            .DATA_W     (DATA_W),
            .SIGNED_CMP (SIGNED_CMP)
        ) u_cell (
            .lo         (e[2*i]),
            .hi         (e[2*i+1]),
            .descending (desc),
            .en         (!phase[0]),
            .lo_out     (even_n[2*i]),
            .hi_out     (even_n[2*i+1])
        );
    end

    if (NUM_ELEM % 2 == 1) begin : g_even_tail
        assign even_n[NUM_ELEM-1] = e[NUM_ELEM-1];
    end

    // Odd network: pairs (1,2), (3,4), ...; lane 0 never has a partner here.
    for (genvar i = 0; i < N_ODD; i++) begin : g_odd
        cmp_exchange_cell #(
            .DATA_W     (DATA_W),
            .SIGNED_CMP (SIGNED_CMP)
        ) u_cell (
            .lo         (e[2*i+1]),
            .hi         (e[2*i+2]),
            .descending (desc),
            .en         (phase[0]),
            .lo_out     (odd_n[2*i+1]),
            .hi_out     (odd_n[2*i+2])
        );
    end

    assign odd_n[0] = e[0];

    if (NUM_ELEM % 2 == 0) begin : g_odd_tail
        assign odd_n[NUM_ELEM-1] = e[NUM_ELEM-1];
    end

    // The largest value sits at the end the order pushes it towards.
    assign max_out = desc ? e[0] : e[NUM_ELEM-1];
    assign min_out = desc ? e[NUM_ELEM-1] : e[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            desc      <= 1'b0;
            phase     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_ELEM; i++) e[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (capture) begin
                        e         <= in_elem;
                        desc      <= descending;
                        phase     <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b0;
                        state     <= SORT;
                    end else if (state == DONE && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                SORT: begin
                    for (int i = 0; i < NUM_ELEM; i++) e[i] <= phase[0] ? odd_n[i] : even_n[i];
                    phase <= phase + 1'b1;
                    if (phase == CNT_W'(NUM_ELEM - 1)) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
